// File: rtl/pose_point_controller.sv
// Button-driven controller for NUM_POINTS tracked 3-D points: per-button sync/debounce,
// hold-to-repeat, point selection and saturating XY/Z/group moves.
module pose_point_controller #(
    parameter int NUM_POINTS      = 5,
    parameter int X_W             = 12,
    parameter int Y_W             = 12,
    parameter int Z_W             = 14,
    parameter int STEP            = 4,
    parameter int X_MAX           = 1023,
    parameter int Y_MAX           = 767,
    parameter int Z_MAX           = 4095,
    parameter int X_INIT          = 512,
    parameter int Y_INIT          = 384,
    parameter int Z_INIT          = 1024,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 19500000,
    parameter int REPEAT_PERIOD   = 3250000,
    localparam int SEL_W          = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      left_button,
    input  logic                      right_button,
    input  logic                      up_button,
    input  logic                      down_button,
    input  logic                      sel_button,
    input  logic [1:0]                mode_in,
    output logic [NUM_POINTS*X_W-1:0] x_out,
    output logic [NUM_POINTS*Y_W-1:0] y_out,
    output logic [NUM_POINTS*Z_W-1:0] z_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      update_out
);

    localparam int NB   = 5;
    localparam int NDIR = 4;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_DELAY + 1);

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int BTN_SEL   = 4;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_FIRST  = RP_W'(REPEAT_DELAY);
    // After a repeat the counter is rewound so the next one lands REPEAT_PERIOD cycles later.
    localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    localparam logic [X_W:0] X_STEP_W = (X_W+1)'(STEP);
    localparam logic [Y_W:0] Y_STEP_W = (Y_W+1)'(STEP);
    localparam logic [Z_W:0] Z_STEP_W = (Z_W+1)'(STEP);
    localparam logic [X_W:0] X_MAX_W  = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] Y_MAX_W  = (Y_W+1)'(Y_MAX);
    localparam logic [Z_W:0] Z_MAX_W  = (Z_W+1)'(Z_MAX);

    logic [NB-1:0]   raw;
    logic [NB-1:0]   sync1;
    logic [NB-1:0]   sync2;
    logic [NB-1:0]   level;
    logic [NB-1:0]   level_d;
    logic [DB_W-1:0] db_cnt [NB];
    logic [RP_W-1:0] rep_cnt [NDIR];

    logic [NB-1:0]   press_ev;
    logic [NDIR-1:0] rep_ev;
    logic [NDIR-1:0] move_ev;
    logic            sel_ev;

    logic [X_W-1:0]  x_q   [NUM_POINTS];
    logic [Y_W-1:0]  y_q   [NUM_POINTS];
    logic [Z_W-1:0]  z_q   [NUM_POINTS];
    logic [X_W-1:0]  x_nxt [NUM_POINTS];
    logic [Y_W-1:0]  y_nxt [NUM_POINTS];
    logic [Z_W-1:0]  z_nxt [NUM_POINTS];
    logic [SEL_W-1:0] sel_q;
    logic            update_q;
    logic            changed;

    logic xy_mode;
    logic z_mode;
    logic x_inc, x_dec, y_inc, y_dec, z_inc, z_dec;

    assign raw = {sel_button, down_button, up_button, right_button, left_button};

    // Synchroniser, debounce and repeat counters for every button.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
            for (int b = 0; b < NDIR; b++) rep_cnt[b] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int b = 0; b < NB; b++) begin
                if (sync2[b] != level[b]) begin
                    if (db_cnt[b] == DB_LAST) begin
                        level[b]  <= sync2[b];
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 1'b1;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
            for (int b = 0; b < NDIR; b++) begin
                if (!level[b])
                    rep_cnt[b] <= '0;
                else if (rep_cnt[b] == RP_FIRST)
                    rep_cnt[b] <= RP_RELOAD;
                else
                    rep_cnt[b] <= rep_cnt[b] + 1'b1;
            end
        end
    end

    always_comb begin
        press_ev = level & ~level_d;
        rep_ev   = '0;
        for (int b = 0; b < NDIR; b++)
            rep_ev[b] = level[b] && (rep_cnt[b] == RP_FIRST);
        move_ev = press_ev[NDIR-1:0] | rep_ev;
        sel_ev  = press_ev[BTN_SEL];
    end

    always_comb begin
        xy_mode = (mode_in == 2'd0) || (mode_in == 2'd2);
        z_mode  = (mode_in == 2'd1);
        x_inc   = xy_mode && move_ev[BTN_RIGHT];
        x_dec   = xy_mode && move_ev[BTN_LEFT];
        y_inc   = xy_mode && move_ev[BTN_DOWN];
        y_dec   = xy_mode && move_ev[BTN_UP];
        z_inc   = z_mode  && move_ev[BTN_UP];
        z_dec   = z_mode  && move_ev[BTN_DOWN];
    end

    // Opposing requests cancel; arithmetic is one bit wider so overflow and borrow are visible.
    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] v, input logic inc, input logic dec);
        logic [X_W:0] wide;
        wide = {1'b0, v};
        if (inc && !dec) begin
            wide = wide + X_STEP_W;
            if (wide > X_MAX_W) wide = X_MAX_W;
        end else if (dec && !inc) begin
            wide = wide - X_STEP_W;
            if (wide[X_W]) wide = '0;
        end
        return wide[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] v, input logic inc, input logic dec);
        logic [Y_W:0] wide;
        wide = {1'b0, v};
        if (inc && !dec) begin
            wide = wide + Y_STEP_W;
            if (wide > Y_MAX_W) wide = Y_MAX_W;
        end else if (dec && !inc) begin
            wide = wide - Y_STEP_W;
            if (wide[Y_W]) wide = '0;
        end
        return wide[Y_W-1:0];
    endfunction

    function automatic logic [Z_W-1:0] step_z(input logic [Z_W-1:0] v, input logic inc, input logic dec);
        logic [Z_W:0] wide;
        wide = {1'b0, v};
        if (inc && !dec) begin
            wide = wide + Z_STEP_W;
            if (wide > Z_MAX_W) wide = Z_MAX_W;
        end else if (dec && !inc) begin
            wide = wide - Z_STEP_W;
            if (wide[Z_W]) wide = '0;
        end
        return wide[Z_W-1:0];
    endfunction

    // Moves use the selection held before any same-cycle sel event.
    always_comb begin
        changed = 1'b0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            x_nxt[i] = x_q[i];
            y_nxt[i] = y_q[i];
            z_nxt[i] = z_q[i];
            if ((mode_in == 2'd2) || (sel_q == SEL_W'(i))) begin
                x_nxt[i] = step_x(x_q[i], x_inc, x_dec);
                y_nxt[i] = step_y(y_q[i], y_inc, y_dec);
                z_nxt[i] = step_z(z_q[i], z_inc, z_dec);
            end
            if ((x_nxt[i] != x_q[i]) || (y_nxt[i] != y_q[i]) || (z_nxt[i] != z_q[i]))
                changed = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                x_q[i] <= X_W'(X_INIT);
                y_q[i] <= Y_W'(Y_INIT);
                z_q[i] <= Z_W'(Z_INIT);
            end
            sel_q    <= '0;
            update_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                x_q[i] <= x_nxt[i];
                y_q[i] <= y_nxt[i];
                z_q[i] <= z_nxt[i];
            end
            if (sel_ev)
                sel_q <= (sel_q == SEL_W'(NUM_POINTS - 1)) ? '0 : sel_q + 1'b1;
            update_q <= changed;
        end
    end

    // Outputs are plain registers, valid every cycle; there is no valid/ready handshake here.
    for (genvar g = 0; g < NUM_POINTS; g++) begin : g_pack
        assign x_out[g*X_W +: X_W] = x_q[g];
        assign y_out[g*Y_W +: Y_W] = y_q[g];
        assign z_out[g*Z_W +: Z_W] = z_q[g];
    end

    assign sel_out    = sel_q;
    assign update_out = update_q;

endmodule

// File: tb/tb_pose_point_controller.sv
// Directed bench for pose_point_controller with short debounce/repeat timings;
// a second instance starts at x=1020 to exercise the upper clamp.
module tb_pose_point_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        left_b = 1'b0, right_b = 1'b0, up_b = 1'b0, down_b = 1'b0, sel_b = 1'b0;
    logic [1:0]  mode = 2'd0;

    logic [59:0] x_m, y_m, x_s, y_s;
    logic [69:0] z_m, z_s;
    logic [2:0]  sel_m, sel_s;
    logic        upd_m, upd_s;

    int checks = 0;
    int failures = 0;
    int upd_cnt_m = 0;
    int upd_cnt_s = 0;
    int exp_sel[6] = '{1, 2, 3, 4, 0, 1};

    always #5 clk = ~clk;

    pose_point_controller #(
        .NUM_POINTS(5), .STEP(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk_in(clk), .rst_in(rst), .left_button(left_b), .right_button(right_b),
        .up_button(up_b), .down_button(down_b), .sel_button(sel_b), .mode_in(mode),
        .x_out(x_m), .y_out(y_m), .z_out(z_m), .sel_out(sel_m), .update_out(upd_m)
    );

    pose_point_controller #(
        .NUM_POINTS(5), .STEP(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8),
        .X_INIT(1020), .X_MAX(1023)
    ) dut_sat (
        .clk_in(clk), .rst_in(rst), .left_button(left_b), .right_button(right_b),
        .up_button(up_b), .down_button(down_b), .sel_button(sel_b), .mode_in(mode),
        .x_out(x_s), .y_out(y_s), .z_out(z_s), .sel_out(sel_s), .update_out(upd_s)
    );

    // Advance n clock edges; sample 1 ns after each edge and tally update pulses.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (upd_m) upd_cnt_m++;
            if (upd_s) upd_cnt_s++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_buttons(input logic [4:0] mask);
        {sel_b, down_b, up_b, right_b, left_b} = mask;
    endtask

    task automatic press(input logic [4:0] mask, input int hold, input int rel);
        set_buttons(mask);
        tick(hold);
        set_buttons(5'b0);
        tick(rel);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    function automatic logic [31:0] xm(input int i); return 32'(x_m[i*12 +: 12]); endfunction
    function automatic logic [31:0] ym(input int i); return 32'(y_m[i*12 +: 12]); endfunction
    function automatic logic [31:0] zm(input int i); return 32'(z_m[i*14 +: 14]); endfunction
    function automatic logic [31:0] xs(input int i); return 32'(x_s[i*12 +: 12]); endfunction

    initial begin
        // Reset state
        tick(2);
        rst = 1'b0;
        tick(1);
        check("reset_x0", xm(0), 512);
        check("reset_x4", xm(4), 512);
        check("reset_y0", ym(0), 384);
        check("reset_z2", zm(2), 1024);
        check("reset_sel", 32'(sel_m), 0);
        check("reset_update", 32'(upd_m), 0);
        check("reset_sat_x0", xs(0), 1020);

        // Two-cycle glitch is rejected
        upd_cnt_m = 0;
        press(5'b00010, 2, 12);
        check("glitch_x0", xm(0), 512);
        check("glitch_pulses", 32'(upd_cnt_m), 0);

        // Clean hold: press at 7, repeats at 27 and 35
        upd_cnt_m = 0;
        set_buttons(5'b00010);
        tick(6);
        check("hold_c6_x0", xm(0), 512);
        tick(1);
        check("hold_c7_x0", xm(0), 516);
        check("hold_c7_update", 32'(upd_m), 1);
        tick(19);
        check("hold_c26_x0", xm(0), 516);
        tick(1);
        check("hold_c27_x0", xm(0), 520);
        tick(7);
        check("hold_c34_x0", xm(0), 520);
        tick(1);
        check("hold_c35_x0", xm(0), 524);
        tick(1);
        set_buttons(5'b0);
        tick(12);
        check("hold_final_x0", xm(0), 524);
        check("hold_x1", xm(1), 512);
        check("hold_y0", ym(0), 384);
        check("hold_pulses", 32'(upd_cnt_m), 3);

        // Selection wraps, then a Z move on point 1
        for (int p = 0; p < 6; p++) begin
            press(5'b10000, 8, 8);
            check($sformatf("sel_after_%0d", p + 1), 32'(sel_m), 32'(exp_sel[p]));
        end
        mode = 2'd1;
        press(5'b01000, 8, 10);
        check("zmode_z1", zm(1), 1020);
        check("zmode_z0", zm(0), 1024);
        check("zmode_y1", ym(1), 384);
        check("zmode_x0", xm(0), 524);

        // Group mode with clamp at X_MAX
        do_reset();
        mode = 2'd2;
        upd_cnt_s = 0;
        press(5'b00010, 8, 10);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("group_sat_x%0d", i), xs(i), 1023);
            check($sformatf("group_main_x%0d", i), xm(i), 516);
        end
        check("group_sat_pulses", 32'(upd_cnt_s), 1);
        upd_cnt_s = 0;
        press(5'b00010, 8, 10);
        check("group_sat_again_x0", xs(0), 1023);
        check("group_sat_again_x4", xs(4), 1023);
        check("group_sat_again_pulses", 32'(upd_cnt_s), 0);
        check("group_main_again_x3", xm(3), 520);

        // Opposing and orthogonal simultaneous events in mode 0
        mode = 2'd0;
        upd_cnt_m = 0;
        press(5'b00011, 8, 10);
        check("cancel_x0", xm(0), 520);
        check("cancel_pulses", 32'(upd_cnt_m), 0);
        set_buttons(5'b00101);
        tick(7);
        check("diag_x0", xm(0), 516);
        check("diag_y0", ym(0), 380);
        check("diag_x1", xm(1), 520);
        check("diag_update", 32'(upd_m), 1);
        set_buttons(5'b0);
        tick(10);

        // Reset during auto-repeat with right still held
        set_buttons(5'b00010);
        tick(25);
        check("prereset_x0", xm(0), 520);
        rst = 1'b1;
        tick(2);
        check("midreset_x0", xm(0), 512);
        check("midreset_x3", xm(3), 512);
        check("midreset_y0", ym(0), 384);
        check("midreset_update", 32'(upd_m), 0);
        rst = 1'b0;
        tick(6);
        check("rerelease_c6_x0", xm(0), 512);
        tick(1);
        check("rerelease_c7_x0", xm(0), 516);
        check("rerelease_c7_update", 32'(upd_m), 1);
        set_buttons(5'b0);
        tick(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
